// File: rtl/pool1_max_write_if.sv
// Handshake and memory-write bundle between the Conv1 read addresser, the
// Pool1 max-pool writer and the Pool1 output memory.
interface pool1_max_write_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in0;
    logic signed [DATA_W-1:0] in1;
    logic signed [DATA_W-1:0] in2;
    logic signed [DATA_W-1:0] in3;
    logic                     wr_en;
    logic        [ADDR_W-1:0] wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic                     busy;
    logic                     done;

    modport master (
        output start, in_valid, in0, in1, in2, in3,
        input  wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  start, in_valid, in0, in1, in2, in3,
        output wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/pool1_max_write.sv
// 2x2 signed max-pool stage: reduces one Conv1 window per cycle through a
// two-stage compare tree and writes results row-major into the Pool1 memory.
module pool1_max_write #(
    parameter int DATA_W  = 16,
    parameter int OUT_DIM = 12,
    parameter int ADDR_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    pool1_max_write_if.slave bus
);
    localparam int TOTAL = OUT_DIM * OUT_DIM;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     w_accept;
    logic                     w_launch;
    logic                     w_busy;
    logic                     w_done;

    logic        [CNT_W-1:0]  r_acc_cnt;
    logic                     r_s1_valid;
    logic signed [DATA_W-1:0] r_m01;
    logic signed [DATA_W-1:0] r_m23;
    logic                     r_wr_en;
    logic        [ADDR_W-1:0] r_wr_addr;
    logic signed [DATA_W-1:0] r_wr_data;

    logic signed [DATA_W-1:0] w_m01;
    logic signed [DATA_W-1:0] w_m23;
    logic signed [DATA_W-1:0] w_max;

    // Operands are declared signed, so these are two's-complement compares.
    assign w_m01 = (bus.in0 > bus.in1) ? bus.in0 : bus.in1;
    assign w_m23 = (bus.in2 > bus.in3) ? bus.in2 : bus.in3;
    assign w_max = (r_m01 > r_m23) ? r_m01 : r_m23;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: each always_comb output is given a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (bus.start) w_next_state = S_RUN;
            S_RUN:          if (w_accept && r_acc_cnt == LAST_BEAT) w_next_state = S_DRAIN;
            // No new beats enter in DRAIN, so S2 firing with S1 empty is the last write.
            S_DRAIN:        if (r_wr_en && !r_s1_valid) w_next_state = S_DONE;
            default:        w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_accept = 1'b0;
        w_launch = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_launch = bus.start;
            end
            S_RUN: begin
                w_busy   = 1'b1;
                w_accept = bus.in_valid;
            end
            S_DRAIN: begin
                w_busy   = 1'b1;
            end
            S_DONE: begin
                w_done   = 1'b1;
                w_launch = bus.start;
            end
            default: begin
                w_busy   = 1'b0;
            end
        endcase
    end

    // Stage 1: pairwise maxima of the top and bottom window rows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc_cnt  <= '0;
            r_s1_valid <= 1'b0;
            r_m01      <= '0;
            r_m23      <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_m01 <= w_m01;
                r_m23 <= w_m23;
            end
            if (w_launch) begin
                r_acc_cnt <= '0;
            end else if (w_accept) begin
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 2: final maximum, write strobe and saturating row-major address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= r_s1_valid;
            if (r_s1_valid) begin
                r_wr_data <= w_max;
            end
            if (w_launch) begin
                r_wr_addr <= '0;
            end else if (r_wr_en && r_wr_addr != LAST_ADDR) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
        end
    end

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
endmodule

// File: tb/tb_pool1_max_write.sv
// Randomized bench for pool1_max_write: a reference model predicts the max of
// every accepted window, and each scenario task compares the observed writes.
module tb_pool1_max_write;
    localparam int DATA_W  = 16;
    localparam int OUT_DIM = 12;
    localparam int ADDR_W  = 8;
    localparam int TOTAL   = OUT_DIM * OUT_DIM;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    wr_t  obs[$];

    pool1_max_write_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    pool1_max_write #(
        .DATA_W (DATA_W),
        .OUT_DIM(OUT_DIM),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance one clock, sample 1 time unit after the edge, log any write.
    task automatic step();
        wr_t w;
        @(posedge clk);
        #1;
        if (bus.wr_en === 1'b1) begin
            w.addr = int'(bus.wr_addr);
            w.data = int'(bus.wr_data);
            w.cyc  = cyc;
            obs.push_back(w);
        end
    endtask

    function automatic int ref_max(input int a, input int b, input int c, input int d);
        int v[4];
        int m;
        v = '{a, b, c, d};
        m = v[0];
        foreach (v[i]) if (v[i] > m) m = v[i];
        return m;
    endfunction

    function automatic int rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        return int'($signed(r));
    endfunction

    function automatic void gen_window(input int pattern, input int k,
                                       output int w0, output int w1, output int w2, output int w3);
        if (pattern == 0) begin
            w0 = k; w1 = k + 1; w2 = -k; w3 = 0;
        end else if (pattern == 2 && k == 0) begin
            w0 = -5; w1 = -3; w2 = -7; w3 = -32768;
        end else if (pattern == 2 && k == 1) begin
            w0 = -32768; w1 = -32768; w2 = -32768; w3 = -32768;
        end else begin
            w0 = rnd16(); w1 = rnd16(); w2 = rnd16(); w3 = rnd16();
        end
    endfunction

    task automatic drive_junk(input logic valid);
        bus.in_valid = valid;
        bus.in0 = 16'($urandom);
        bus.in1 = 16'($urandom);
        bus.in2 = 16'($urandom);
        bus.in3 = 16'($urandom);
    endtask

    // Full pass: optional start, 144 windows with optional gaps, then compare
    // every write against the model for address, data and 2-cycle latency.
    task automatic run_pass(input int pattern, input int max_gap, input bit do_start,
                            input bit mid_start, input string name);
        int acc[$];
        int expd[$];
        int w0, w1, w2, w3;
        int busy_low  = 0;
        int done_cyc  = -1;
        logic done_busy = 1'bx;
        obs.delete();
        if (do_start) begin
            bus.start = 1'b1;
            drive_junk(1'b0);
            step();
            bus.start = 1'b0;
        end
        for (int k = 0; k < TOTAL; k++) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(0, max_gap);
                for (int j = 0; j < g; j++) begin
                    drive_junk(1'b0);
                    step();
                    if (bus.busy !== 1'b1) busy_low++;
                end
            end
            gen_window(pattern, k, w0, w1, w2, w3);
            bus.in0 = 16'(w0);
            bus.in1 = 16'(w1);
            bus.in2 = 16'(w2);
            bus.in3 = 16'(w3);
            bus.in_valid = 1'b1;
            bus.start = mid_start && (k == TOTAL / 2);
            expd.push_back(ref_max(w0, w1, w2, w3));
            acc.push_back(cyc);
            step();
            if (bus.busy !== 1'b1) busy_low++;
        end
        bus.start = 1'b0;
        drive_junk(1'b0);
        for (int t = 0; t < 20 && done_cyc < 0; t++) begin
            step();
            if (bus.done === 1'b1) begin
                done_cyc  = cyc;
                done_busy = bus.busy;
            end else if (bus.busy !== 1'b1) begin
                busy_low++;
            end
        end

        total++;
        if (done_cyc < 0) begin
            bad++; $display("FAIL %s done_timeout: done never rose within 20 cycles", name);
        end
        total++;
        if (busy_low !== 0) begin
            bad++; $display("FAIL %s busy_during_pass: low for %0d cycles, required 0", name, busy_low);
        end
        total++;
        if (done_busy !== 1'b0) begin
            bad++; $display("FAIL %s busy_at_done: got %b, required 0", name, done_busy);
        end
        total++;
        if (obs.size() !== TOTAL) begin
            bad++; $display("FAIL %s write_count: got %0d, required %0d", name, obs.size(), TOTAL);
        end
        for (int i = 0; i < obs.size() && i < TOTAL; i++) begin
            total++;
            if (obs[i].addr !== i) begin
                bad++; $display("FAIL %s addr[%0d]: got %0d, required %0d", name, i, obs[i].addr, i);
            end
            total++;
            if (obs[i].data !== expd[i]) begin
                bad++; $display("FAIL %s data[%0d]: got %0d, required %0d", name, i, obs[i].data, expd[i]);
            end
            total++;
            if (obs[i].cyc - acc[i] !== 2) begin
                bad++; $display("FAIL %s latency[%0d]: got %0d, required 2", name, i, obs[i].cyc - acc[i]);
            end
        end
        if (obs.size() > 0 && done_cyc >= 0) begin
            total++;
            if (done_cyc !== obs[obs.size()-1].cyc + 1) begin
                bad++; $display("FAIL %s done_timing: rose %0d cycles after last write, required 1",
                                name, done_cyc - obs[obs.size()-1].cyc);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start = 1'b0;
        drive_junk(1'b1);
        step();
        step();
        total++;
        if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset wr_en: got %b, required 0", bus.wr_en); end
        total++;
        if (bus.wr_addr !== '0) begin bad++; $display("FAIL reset wr_addr: got %0d, required 0", bus.wr_addr); end
        total++;
        if (bus.wr_data !== '0) begin bad++; $display("FAIL reset wr_data: got %0d, required 0", bus.wr_data); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b, required 0", bus.busy); end
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset done: got %b, required 0", bus.done); end
        reset_n = 1'b1;
        drive_junk(1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        run_pass(0, 0, 1'b1, 1'b0, "back_to_back");
        // After the pass the address must saturate at 143 and no more writes appear.
        for (int i = 0; i < 4; i++) begin
            drive_junk(1'b0);
            step();
        end
        total++;
        if (bus.wr_addr !== ADDR_W'(TOTAL - 1)) begin
            bad++; $display("FAIL back_to_back addr_hold: got %0d, required %0d", bus.wr_addr, TOTAL - 1);
        end
        total++;
        if (obs.size() !== TOTAL) begin
            bad++; $display("FAIL back_to_back extra_writes: got %0d writes, required %0d", obs.size(), TOTAL);
        end
    endtask

    task automatic test_signed();
        run_pass(2, 0, 1'b1, 1'b0, "signed");
        if (obs.size() >= 2) begin
            total++;
            if (obs[0].data !== -3) begin
                bad++; $display("FAIL signed mixed_negatives: got %0d, required -3", obs[0].data);
            end
            total++;
            if (obs[1].data !== -32768) begin
                bad++; $display("FAIL signed all_min: got %0d, required -32768", obs[1].data);
            end
        end
    endtask

    task automatic test_gaps();
        run_pass(1, 3, 1'b1, 1'b0, "gaps");
    endtask

    task automatic test_stray();
        reset_n = 1'b0;
        bus.start = 1'b0;
        step();
        reset_n = 1'b1;
        obs.delete();
        for (int i = 0; i < 5; i++) begin
            drive_junk(1'b1);
            step();
        end
        total++;
        if (obs.size() !== 0) begin
            bad++; $display("FAIL stray idle_writes: got %0d, required 0", obs.size());
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL stray idle_busy: got %b, required 0", bus.busy);
        end

        run_pass(1, 0, 1'b1, 1'b1, "mid_run_start");

        obs.delete();
        for (int i = 0; i < 5; i++) begin
            drive_junk(1'b1);
            step();
        end
        total++;
        if (obs.size() !== 0) begin
            bad++; $display("FAIL stray done_writes: got %0d, required 0", obs.size());
        end
        total++;
        if (bus.done !== 1'b1) begin
            bad++; $display("FAIL stray done_sticky: got %b, required 1", bus.done);
        end

        // start together with in_valid in DONE: the beat must be dropped.
        bus.start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in0 = 16'h7fff;
        bus.in1 = 16'h7fff;
        bus.in2 = 16'h7fff;
        bus.in3 = 16'h7fff;
        step();
        bus.start = 1'b0;
        total++;
        if (bus.done !== 1'b0) begin
            bad++; $display("FAIL stray restart_done: got %b, required 0", bus.done);
        end
        total++;
        if (bus.wr_addr !== '0) begin
            bad++; $display("FAIL stray restart_addr: got %0d, required 0", bus.wr_addr);
        end
        run_pass(1, 0, 1'b0, 1'b0, "restart");
    endtask

    task automatic test_reset_mid();
        int n;
        obs.delete();
        bus.start = 1'b1;
        drive_junk(1'b0);
        step();
        bus.start = 1'b0;
        n = 0;
        while (obs.size() < 50 && n < 200) begin
            drive_junk(1'b1);
            step();
            n++;
        end
        total++;
        if (obs.size() !== 50) begin
            bad++; $display("FAIL reset_mid pre_writes: got %0d, required 50", obs.size());
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({bus.wr_en, bus.busy, bus.done} !== 3'b000) begin
            bad++; $display("FAIL reset_mid flags: got wr_en/busy/done=%b%b%b, required 000",
                            bus.wr_en, bus.busy, bus.done);
        end
        total++;
        if (bus.wr_addr !== '0 || bus.wr_data !== '0) begin
            bad++; $display("FAIL reset_mid data: got addr=%0d data=%0d, required 0/0",
                            bus.wr_addr, bus.wr_data);
        end
        for (int i = 0; i < 3; i++) begin
            drive_junk(1'b1);
            step();
        end
        reset_n = 1'b1;
        drive_junk(1'b1);
        for (int i = 0; i < 3; i++) step();
        total++;
        if (obs.size() !== 50) begin
            bad++; $display("FAIL reset_mid post_writes: got %0d, required 50", obs.size());
        end
        run_pass(1, 0, 1'b1, 1'b0, "after_reset");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in0 = '0;
        bus.in1 = '0;
        bus.in2 = '0;
        bus.in3 = '0;
        reset_n = 1'b0;
        test_reset();
        test_back_to_back();
        test_signed();
        test_gaps();
        test_stray();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
